// File: rtl/bist_signature_checker.sv
// BIST response analyser: runs a CYCLES-long window, then captures and compares the MISR signature.
// Latency: done strobes CYCLES+1 clocks after start is sampled. No backpressure; start is ignored unless idle.
// Optional BIST_FAILCNT_EN adds a saturating 8-bit fail_cnt output.
module bist_signature_checker #(
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] GOLDEN = '0,
    parameter int               CYCLES = 1000,
    parameter int               CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [SIG_W-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig_cap
`ifdef BIST_FAILCNT_EN
    ,
    output logic [7:0]       fail_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [SIG_W-1:0] sig_cap_q, sig_cap_d;
`ifdef BIST_FAILCNT_EN
    logic [7:0]       fail_cnt_q, fail_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        sig_cap_d = sig_cap_q;
`ifdef BIST_FAILCNT_EN
        fail_cnt_d = fail_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                // cnt peaks at CYCLES, which the legal range keeps below wrap.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                sig_cap_d = sig;
                pass_d    = (sig == GOLDEN);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
`ifdef BIST_FAILCNT_EN
                if ((sig != GOLDEN) && (fail_cnt_q != 8'hFF)) begin
                    fail_cnt_d = fail_cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            sig_cap_q <= '0;
`ifdef BIST_FAILCNT_EN
            fail_cnt_q <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            sig_cap_q <= sig_cap_d;
`ifdef BIST_FAILCNT_EN
            fail_cnt_q <= fail_cnt_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign sig_cap = sig_cap_q;
`ifdef BIST_FAILCNT_EN
    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_bist_signature_checker.sv
// Bench for bist_signature_checker: three instances (CYCLES 8, 4, 1) checked every clock
// against a session-timeline reference model.
module tb_bist_signature_checker;

    localparam logic [15:0] G8 = 16'hA5C3;
    localparam logic [15:0] G4 = 16'h3C5A;
    localparam logic [15:0] G1 = 16'h1234;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        start8, start4, start1;
    logic [15:0] sig8, sig4, sig1;
    logic        busy8, done8, pass8, busy4, done4, pass4, busy1, done1, pass1;
    logic [15:0] cap8, cap4, cap1;
`ifdef BIST_FAILCNT_EN
    logic [7:0]  fc8, fc4, fc1;
`endif

    bist_signature_checker #(.SIG_W(16), .GOLDEN(G8), .CYCLES(8), .CNT_W(16)) dut8 (
        .CLK(CLK), .RST(RST), .start(start8), .sig(sig8), .busy(busy8), .done(done8),
        .pass(pass8), .sig_cap(cap8)
`ifdef BIST_FAILCNT_EN
        , .fail_cnt(fc8)
`endif
    );
    bist_signature_checker #(.SIG_W(16), .GOLDEN(G4), .CYCLES(4), .CNT_W(3)) dut4 (
        .CLK(CLK), .RST(RST), .start(start4), .sig(sig4), .busy(busy4), .done(done4),
        .pass(pass4), .sig_cap(cap4)
`ifdef BIST_FAILCNT_EN
        , .fail_cnt(fc4)
`endif
    );
    bist_signature_checker #(.SIG_W(16), .GOLDEN(G1), .CYCLES(1), .CNT_W(4)) dut1 (
        .CLK(CLK), .RST(RST), .start(start1), .sig(sig1), .busy(busy1), .done(done1),
        .pass(pass1), .sig_cap(cap1)
`ifdef BIST_FAILCNT_EN
        , .fail_cnt(fc1)
`endif
    );

    // Reference model: each session is an acceptance edge number; verdict lands CYCLES+1 edges later.
    int          m_c[3] = '{8, 4, 1};
    logic [15:0] m_g[3];
    int          m_acc[3] = '{-1, -1, -1};
    logic        m_done[3], m_pass[3];
    logic [15:0] m_cap[3];
    int          m_fc[3];
    int          now = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [26:0] v_o, v_e;

    function automatic logic start_of(int d);
        return (d == 0) ? start8 : (d == 1) ? start4 : start1;
    endfunction

    function automatic logic [15:0] sig_of(int d);
        return (d == 0) ? sig8 : (d == 1) ? sig4 : sig1;
    endfunction

    function automatic void model_edge(int d, logic st, logic [15:0] sg);
        m_done[d] = 1'b0;
        if (RST) begin
            m_acc[d] = -1; m_pass[d] = 1'b0; m_cap[d] = 16'h0; m_fc[d] = 0;
        end else if (m_acc[d] >= 0 && now == m_acc[d] + m_c[d] + 1) begin
            m_done[d] = 1'b1;
            m_cap[d]  = sg;
            m_pass[d] = (sg == m_g[d]);
            if (!m_pass[d] && m_fc[d] < 255) m_fc[d]++;
            m_acc[d] = -1;
        end else if (m_acc[d] < 0 && st) begin
            m_acc[d] = now;
        end
    endfunction

    function automatic logic [26:0] obs(int d);
        logic [7:0] f;
        f = 8'h00;
        case (d)
            0: begin
`ifdef BIST_FAILCNT_EN
                f = fc8;
`endif
                return {busy8, done8, pass8, cap8, f};
            end
            1: begin
`ifdef BIST_FAILCNT_EN
                f = fc4;
`endif
                return {busy4, done4, pass4, cap4, f};
            end
            default: begin
`ifdef BIST_FAILCNT_EN
                f = fc1;
`endif
                return {busy1, done1, pass1, cap1, f};
            end
        endcase
    endfunction

    function automatic logic [26:0] expv(int d);
        logic [7:0] f;
        f = 8'h00;
`ifdef BIST_FAILCNT_EN
        f = 8'(m_fc[d]);
`endif
        return {(m_acc[d] >= 0), m_done[d], m_pass[d], m_cap[d], f};
    endfunction

    task automatic tick();
        @(posedge CLK);
        now++;
        for (int d = 0; d < 3; d++) model_edge(d, start_of(d), sig_of(d));
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                v_o = obs(d); v_e = expv(d); n_cmp++;
                if (v_o !== v_e) begin
                    n_bad++;
                    $display("FAIL reset dut%0d edge %0d: got %h expected %h", d, now, v_o, v_e);
                end
            end
        end
        v_o = obs(0); n_cmp++;
        if (v_o !== 27'h0) begin
            n_bad++;
            $display("FAIL reset_zero: got %h expected 0", v_o);
        end
        RST = 1'b0;
    endtask

    task automatic test_verdict(input string name, input logic [15:0] sv);
        int k, de;
        de = -1;
        sig8 = sv; start8 = 1'b1;
        tick();
        k = now; start8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            v_o = obs(0); v_e = expv(0); n_cmp++;
            if (v_o !== v_e) begin
                n_bad++;
                $display("FAIL %s edge %0d: got %h expected %h", name, now, v_o, v_e);
            end
            if (done8 === 1'b1) de = now;
            tick();
        end
        n_cmp++;
        if (de !== k + 9 || pass8 !== (sv == G8) || cap8 !== sv) begin
            n_bad++;
            $display("FAIL %s_result: done_edge %0d pass %b cap %h, expected done_edge %0d pass %b cap %h",
                     name, de, pass8, cap8, k + 9, (sv == G8), sv);
        end
    endtask

    task automatic test_back_to_back();
        int last, ndone;
        last = -1; ndone = 0;
        start4 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            sig4 = ($urandom_range(0, 1) == 1) ? G4 : 16'($urandom);
            v_o = obs(1); v_e = expv(1); n_cmp++;
            if (v_o !== v_e) begin
                n_bad++;
                $display("FAIL back_to_back edge %0d: got %h expected %h", now, v_o, v_e);
            end
            if (done4 === 1'b1) begin
                ndone++;
                if (last >= 0) begin
                    n_cmp++;
                    if (now - last !== 6) begin
                        n_bad++;
                        $display("FAIL b2b_period: got %0d expected 6", now - last);
                    end
                end
                last = now;
            end
        end
        n_cmp++;
        if (ndone < 7) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d expected at least 7", ndone);
        end
        start4 = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset_mid();
        int k, de;
        sig8 = G8; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_cmp++;
        if (pass8 !== 1'b0 || cap8 !== 16'h0 || busy8 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_clear: pass %b cap %h busy %b expected 0 0000 0", pass8, cap8, busy8);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            v_o = obs(0); v_e = expv(0); n_cmp++;
            if (v_o !== v_e || done8 !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset_quiet edge %0d: got %h expected %h", now, v_o, v_e);
            end
        end
        de = -1;
        start8 = 1'b1;
        tick();
        k = now; start8 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (done8 === 1'b1) de = now;
        end
        n_cmp++;
        if (de !== k + 9) begin
            n_bad++;
            $display("FAIL mid_reset_restart: done edge %0d expected %0d", de, k + 9);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start8 = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       sig8 = G8;
                1:       sig8 = G8 ^ (16'h1 << $urandom_range(0, 15));
                default: sig8 = 16'($urandom);
            endcase
            tick();
            v_o = obs(0); v_e = expv(0); n_cmp++;
            if (v_o !== v_e) begin
                n_bad++;
                $display("FAIL random edge %0d: got %h expected %h", now, v_o, v_e);
            end
        end
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_saturation();
        start1 = 1'b1;
        for (int i = 0; i < 840; i++) begin
            if (i < 30 && $urandom_range(0, 1) == 1) sig1 = G1;
            else sig1 = G1 ^ 16'($urandom_range(1, 65535));
            tick();
            v_o = obs(2); v_e = expv(2); n_cmp++;
            if (v_o !== v_e) begin
                n_bad++;
                $display("FAIL saturation edge %0d: got %h expected %h", now, v_o, v_e);
            end
        end
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
`ifdef BIST_FAILCNT_EN
        if (fc1 !== 8'd255) begin
            n_bad++;
            $display("FAIL fail_cnt_sat: got %0d expected 255", fc1);
        end
`else
        if (pass1 !== 1'b0 || busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL cycles1_end: pass %b busy %b expected 0 0", pass1, busy1);
        end
`endif
    endtask

    initial begin
        m_g[0] = G8; m_g[1] = G4; m_g[2] = G1;
        RST = 1'b1;
        start8 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        sig8 = 16'h0; sig4 = 16'h0; sig1 = 16'h0;
        test_reset();
        test_verdict("pass_case", 16'hA5C3);
        test_verdict("fail_case", 16'hA5C2);
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
